lfsr_stream_gen: RTL and testbench

Parametrised multi-lane pseudo-random stream source feeding the matcher's input stream. It replaces hand-instantiated fixed LFSR banks with one block that has LANES independent XNOR-feedback LFSRs and per-lane seed derivation. It adds a valid/ready handshake, free-run and counted-burst modes, per-lane period-completion (loop) flags, and a transfer counter readable through the data-memory register map. It sits between the matching controller (start/stop/mode) and the matcher stream input.

---
 rtl/lfsr_stream_gen.sv | 168 ++++++++++++++++
 tb/tb_lfsr_stream_gen.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_stream_gen.sv
// lfsr_stream_gen: multi-lane XNOR-feedback LFSR stream source with
// valid/ready, free-run/burst modes, loop flags and a transfer counter.
module lfsr_stream_gen #(
    parameter int                    LANE_WIDTH  = 128,
    parameter int                    LANES       = 4,
    parameter logic [LANE_WIDTH-1:0] TAP_MASK    =
        128'hA000_0014_0000_0000_0000_0000_0000_0000,
    parameter int                    COUNT_WIDTH = 32
) (
    input  logic                        i_fclk,
    input  logic                        i_reset_n,
    input  logic                        i_start,
    input  logic                        i_stop,
    input  logic                        i_mode,
    input  logic [COUNT_WIDTH-1:0]      i_burst_len,
    input  logic [LANE_WIDTH-1:0]       i_seed,
    output logic [LANES*LANE_WIDTH-1:0] o_data,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic                        o_busy,
    output logic                        o_done,
    output logic [LANES-1:0]            o_loop,
    output logic [COUNT_WIDTH-1:0]      o_word_count
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic stop_q;
    logic stop_d;
    logic valid_q;
    logic busy_q;
    logic done_q;
    logic done_d;
    logic mode_q;
    logic load;
    logic xfer;
    logic burst_hit;

    logic [COUNT_WIDTH-1:0] burst_len_q;
    logic [COUNT_WIDTH-1:0] burst_cnt_q;
    logic [COUNT_WIDTH-1:0] word_cnt_q;

    assign xfer      = valid_q && i_ready;
    assign burst_hit = (burst_cnt_q + COUNT_WIDTH'(1)) == burst_len_q;

    // Completion beats a pending or same-cycle stop on the last word.
    always_comb begin
        state_d = state_q;
        stop_d  = stop_q;
        done_d  = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (i_start) begin
                    load   = 1'b1;
                    stop_d = 1'b0;
                    if (i_mode && (i_burst_len == '0)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (i_stop) begin
                    stop_d = 1'b1;
                end
                if (xfer) begin
                    if (mode_q && burst_hit) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        stop_d  = 1'b0;
                    end else if (stop_q || i_stop) begin
                        state_d = IDLE;
                        stop_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                stop_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_fclk) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            stop_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stop_q  <= stop_d;
            valid_q <= (state_d == RUN);
            busy_q  <= (state_d == RUN);
            done_q  <= done_d;
        end
    end

    always_ff @(posedge i_fclk) begin
        if (!i_reset_n) begin
            mode_q      <= 1'b0;
            burst_len_q <= '0;
            burst_cnt_q <= '0;
            word_cnt_q  <= '0;
        end else if (load) begin
            mode_q      <= i_mode;
            burst_len_q <= i_burst_len;
            burst_cnt_q <= '0;
            word_cnt_q  <= '0;
        end else if (xfer) begin
            burst_cnt_q <= burst_cnt_q + COUNT_WIDTH'(1);
            word_cnt_q  <= word_cnt_q + COUNT_WIDTH'(1);
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        localparam logic [7:0] IDX = 8'(k);

        logic [LANE_WIDTH-1:0] lane_q;
        logic [LANE_WIDTH-1:0] seed_q;
        logic [LANE_WIDTH-1:0] mixed;
        logic [LANE_WIDTH-1:0] derived;
        logic [LANE_WIDTH-1:0] nxt;
        logic                  loop_q;

        // All-ones is the XNOR lock-up state, so it is never loaded.
        assign mixed   = i_seed ^ {(LANE_WIDTH/8){IDX}};
        assign derived = (&mixed) ? '0 : mixed;
        assign nxt     = {lane_q[LANE_WIDTH-2:0], ~^(lane_q & TAP_MASK)};

        always_ff @(posedge i_fclk) begin
            if (!i_reset_n) begin
                lane_q <= '0;
                seed_q <= '0;
                loop_q <= 1'b0;
            end else if (load) begin
                lane_q <= derived;
                seed_q <= derived;
                loop_q <= 1'b0;
            end else if (xfer) begin
                lane_q <= nxt;
                if (nxt == seed_q) begin
                    loop_q <= 1'b1;
                end
            end
        end

        assign o_data[k*LANE_WIDTH +: LANE_WIDTH] = lane_q;
        assign o_loop[k] = loop_q;
    end

    assign o_valid      = valid_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_word_count = word_cnt_q;

endmodule

// File: tb/tb_lfsr_stream_gen.sv
// tb_lfsr_stream_gen: directed + randomized checks of lfsr_stream_gen
// against a sequence-level reference model.
module tb_lfsr_stream_gen;

    localparam int W  = 8;
    localparam int L  = 2;
    localparam int CW = 32;
    localparam int BW = 128;
    localparam int BL = 4;
    localparam logic [127:0] B_TAPS =
        128'hA000_0014_0000_0000_0000_0000_0000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start;
    logic          stop;
    logic          mode;
    logic          ready;
    logic [CW-1:0] blen;
    logic [W-1:0]  seed;
    logic [L*W-1:0] data;
    logic          valid;
    logic          busy;
    logic          done;
    logic [L-1:0]  loopf;
    logic [CW-1:0] wc;

    logic            b_rst_n;
    logic            b_start;
    logic            b_stop;
    logic            b_mode;
    logic            b_ready;
    logic [CW-1:0]   b_blen;
    logic [BW-1:0]   b_seed;
    logic [BL*BW-1:0] b_data;
    logic            b_valid;
    logic            b_busy;
    logic            b_done;
    logic [BL-1:0]   b_loop;
    logic [CW-1:0]   b_wc;

    lfsr_stream_gen #(
        .LANE_WIDTH (W),
        .LANES      (L),
        .TAP_MASK   (8'hB8),
        .COUNT_WIDTH(CW)
    ) u_dut (
        .i_fclk      (clk),
        .i_reset_n   (rst_n),
        .i_start     (start),
        .i_stop      (stop),
        .i_mode      (mode),
        .i_burst_len (blen),
        .i_seed      (seed),
        .o_data      (data),
        .o_valid     (valid),
        .i_ready     (ready),
        .o_busy      (busy),
        .o_done      (done),
        .o_loop      (loopf),
        .o_word_count(wc)
    );

    lfsr_stream_gen u_dut_def (
        .i_fclk      (clk),
        .i_reset_n   (b_rst_n),
        .i_start     (b_start),
        .i_stop      (b_stop),
        .i_mode      (b_mode),
        .i_burst_len (b_blen),
        .i_seed      (b_seed),
        .o_data      (b_data),
        .o_valid     (b_valid),
        .i_ready     (b_ready),
        .o_busy      (b_busy),
        .o_done      (b_done),
        .o_loop      (b_loop),
        .o_word_count(b_wc)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: lane contents as plain sequences of LFSR values.
    int           mw;
    int           mn;
    logic [127:0] mtaps;
    logic [127:0] ml [4];
    logic [127:0] ms [4];
    logic [3:0]   mloop;
    logic [31:0]  mcnt;

    task automatic check(input string tag, input logic [511:0] obs,
                         input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] m_mask(input int w);
        logic [127:0] m;
        m = '1;
        return m >> (128 - w);
    endfunction

    // Feedback bit is 1 when an even number of tapped bits are set.
    function automatic logic [127:0] m_step(input logic [127:0] s,
                                            input int w,
                                            input logic [127:0] taps);
        int n;
        n = 0;
        for (int i = 0; i < w; i++) begin
            if (taps[i] && s[i]) n++;
        end
        return ((s << 1) | 128'(n % 2 == 0)) & m_mask(w);
    endfunction

    function automatic logic [127:0] m_seed(input logic [127:0] base,
                                            input int w, input int k);
        logic [127:0] s;
        logic [7:0]   kb;
        kb = 8'(k);
        s  = base & m_mask(w);
        for (int b = 0; b < w / 8; b++) begin
            s = s ^ ({120'b0, kb} << (8 * b));
        end
        if (s == m_mask(w)) s = '0;
        return s;
    endfunction

    task automatic m_load(input logic [127:0] base);
        for (int k = 0; k < mn; k++) begin
            ml[k] = m_seed(base, mw, k);
            ms[k] = ml[k];
        end
        mloop = '0;
        mcnt  = '0;
    endtask

    task automatic m_xfer();
        for (int k = 0; k < mn; k++) begin
            ml[k] = m_step(ml[k], mw, mtaps);
            if (ml[k] == ms[k]) mloop[k] = 1'b1;
        end
        mcnt = mcnt + 32'd1;
    endtask

    function automatic logic [511:0] m_word();
        logic [511:0] w;
        w = '0;
        for (int k = 0; k < mn; k++) begin
            w = w | (512'(ml[k]) << (k * mw));
        end
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_a(input logic md, input logic [31:0] bl,
                           input logic [7:0] sd);
        start = 1'b1;
        mode  = md;
        blen  = bl;
        seed  = sd;
        tick();
        start = 1'b0;
        m_load({120'b0, sd});
    endtask

    task automatic cyc_a(input logic r, input string tag);
        logic x;
        ready = r;
        x = valid && r;
        tick();
        if (x) m_xfer();
        check({tag, "_data"}, 512'(data), m_word());
        check({tag, "_wc"}, 512'(wc), 512'(mcnt));
        check({tag, "_loop"}, 512'(loopf), 512'(mloop));
    endtask

    logic [L*W-1:0] prev;
    logic           was;
    logic [127:0]   bseed;
    int             xf;
    int             c;

    initial begin
        mw = W; mn = L; mtaps = 128'hB8;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0;
        ready = 1'b0; blen = '0; seed = '0;
        b_rst_n = 1'b0; b_start = 1'b0; b_stop = 1'b0; b_mode = 1'b0;
        b_ready = 1'b0; b_blen = '0; b_seed = '0;
        tick();
        tick();
        check("rst_valid", 512'(valid), 512'(0));
        check("rst_busy", 512'(busy), 512'(0));
        check("rst_done", 512'(done), 512'(0));
        check("rst_data", 512'(data), 512'(0));
        check("rst_loop", 512'(loopf), 512'(0));
        check("rst_wc", 512'(wc), 512'(0));
        rst_n = 1'b1;
        b_rst_n = 1'b1;
        tick();

        // 1: free-run from seed 0
        ready = 1'b1;
        start_a(1'b0, 32'd0, 8'h00);
        check("s1_w0", 512'(data), 512'(16'h0100));
        check("s1_valid", 512'(valid), 512'(1));
        check("s1_busy", 512'(busy), 512'(1));
        cyc_a(1'b1, "s1a");
        check("s1_w1", 512'(data), 512'(16'h0301));
        check("s1_wc1", 512'(wc), 512'(1));
        cyc_a(1'b1, "s1b");
        check("s1_w2", 512'(data), 512'(16'h0703));
        check("s1_wc2", 512'(wc), 512'(2));
        cyc_a(1'b1, "s1c");
        check("s1_wc3", 512'(wc), 512'(3));
        stop = 1'b1;
        cyc_a(1'b1, "s1s");
        stop = 1'b0;
        check("s1_idle_busy", 512'(busy), 512'(0));
        check("s1_idle_valid", 512'(valid), 512'(0));
        check("s1_idle_done", 512'(done), 512'(0));

        // 2: burst of 5 with ready toggling
        start_a(1'b1, 32'd5, 8'($urandom));
        xf = 0;
        c  = 0;
        while (xf < 5 && c < 40) begin
            was  = valid && (c % 2 == 0);
            prev = data;
            cyc_a(1'(c % 2 == 0), "s2");
            c++;
            if (was) xf++;
            else check("s2_stall", 512'(data), 512'(prev));
            if (xf < 5) check("s2_nodone", 512'(done), 512'(0));
        end
        check("s2_xfers", 512'(xf), 512'(5));
        check("s2_valid_off", 512'(valid), 512'(0));
        check("s2_done", 512'(done), 512'(1));
        check("s2_busy", 512'(busy), 512'(0));
        check("s2_wc", 512'(wc), 512'(5));
        ready = 1'b1;
        tick();
        check("s2_done_once", 512'(done), 512'(0));
        check("s2_valid_stay", 512'(valid), 512'(0));

        // 3: full period, loop flags exactly at transfer 255
        start_a(1'b0, 32'd0, 8'($urandom));
        for (int i = 0; i < 255; i++) begin
            cyc_a(1'b1, "s3");
            check("s3_loop_at", 512'(loopf),
                  512'((i == 254) ? 2'b11 : 2'b00));
        end
        check("s3_back_to_seed", 512'(data), 512'({ms[1][7:0], ms[0][7:0]}));
        stop = 1'b1;
        cyc_a(1'b1, "s3s");
        stop = 1'b0;
        check("s3_stopped", 512'(busy), 512'(0));

        // 4: lock-up substitution, plus start in RUN ignored
        start_a(1'b0, 32'd0, 8'hFF);
        check("s4_seed", 512'(data), 512'(16'hFE00));
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                start = 1'b1;
                seed  = 8'h3C;
            end
            cyc_a(1'($urandom_range(0, 1)), "s4");
            start = 1'b0;
            check("s4_nolock",
                  512'((data[7:0] == 8'hFF) || (data[15:8] == 8'hFF)),
                  512'(0));
        end
        stop = 1'b1;
        cyc_a(1'b0, "s4s");
        stop = 1'b0;
        cyc_a(1'b1, "s4t");
        check("s4_stopped", 512'(busy), 512'(0));

        // 5: stop while stalled, exit on the next transfer
        start_a(1'b0, 32'd0, 8'($urandom));
        stop = 1'b1;
        cyc_a(1'b0, "s5");
        stop = 1'b0;
        cyc_a(1'b0, "s5");
        cyc_a(1'b0, "s5");
        check("s5_still_busy", 512'(busy), 512'(1));
        check("s5_still_valid", 512'(valid), 512'(1));
        cyc_a(1'b1, "s5x");
        check("s5_wc", 512'(wc), 512'(1));
        check("s5_busy", 512'(busy), 512'(0));
        check("s5_valid", 512'(valid), 512'(0));
        check("s5_nodone", 512'(done), 512'(0));
        tick();
        check("s5_nodone2", 512'(done), 512'(0));

        // zero-length burst goes straight to DONE
        start_a(1'b1, 32'd0, 8'($urandom));
        check("z_valid", 512'(valid), 512'(0));
        check("z_done", 512'(done), 512'(1));
        check("z_busy", 512'(busy), 512'(0));
        tick();
        check("z_done_once", 512'(done), 512'(0));

        // start+stop together from DONE: start wins, stop not latched
        stop = 1'b1;
        start_a(1'b0, 32'd0, 8'($urandom));
        stop = 1'b0;
        check("ss_busy", 512'(busy), 512'(1));
        cyc_a(1'b1, "ss");
        check("ss_still_run", 512'(busy), 512'(1));

        // burst end and stop on the same transfer: completion wins
        stop = 1'b1;
        cyc_a(1'b1, "ss_end");
        stop = 1'b0;
        start_a(1'b1, 32'd2, 8'($urandom));
        cyc_a(1'b1, "bs");
        stop = 1'b1;
        cyc_a(1'b1, "bs");
        stop = 1'b0;
        check("bs_done", 512'(done), 512'(1));
        check("bs_busy", 512'(busy), 512'(0));

        // 6: default parameters, reset mid-burst
        mw = BW; mn = BL; mtaps = B_TAPS;
        bseed = {$urandom, $urandom, $urandom, $urandom};
        b_ready = 1'b1;
        b_mode  = 1'b1;
        b_blen  = 32'd10;
        b_seed  = bseed;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        m_load(bseed);
        check("s6_w0", 512'(b_data), m_word());
        check("s6_valid", 512'(b_valid), 512'(1));
        for (int i = 0; i < 3; i++) begin
            tick();
            m_xfer();
            check("s6_data", 512'(b_data), m_word());
            check("s6_wc", 512'(b_wc), 512'(mcnt));
        end
        b_rst_n = 1'b0;
        tick();
        b_rst_n = 1'b1;
        check("s6_rst_valid", 512'(b_valid), 512'(0));
        check("s6_rst_busy", 512'(b_busy), 512'(0));
        check("s6_rst_loop", 512'(b_loop), 512'(0));
        check("s6_rst_wc", 512'(b_wc), 512'(0));
        check("s6_rst_data", 512'(b_data), 512'(0));
        check("s6_rst_done", 512'(b_done), 512'(0));
        tick();
        check("s6_nodone", 512'(b_done), 512'(0));
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        m_load(bseed);
        check("s6_restart", 512'(b_data), m_word());
        check("s6_restart_valid", 512'(b_valid), 512'(1));
        check("s6_restart_wc", 512'(b_wc), 512'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
